// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: instruction width, default PC width and reset
// vector, and the {pc, instr} bundle carried from fetch to decode.
package riscv_pkg;

    localparam int ILEN = 32;
    localparam int XLEN_DEFAULT = 64;
    localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [ILEN-1:0]         instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch_entry_t with wrap-around pointers, a separate
// occupancy counter and a single-cycle flush.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: credit-limited request issue, stale-response
// dropping on redirect, prefetch queue to decode. IF_PREFETCH_BYPASS_EN adds an empty-queue bypass.
module if_prefetch_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [CW-1:0]   q_count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] redir_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop;
    logic [CW:0]     committed;
    logic            accept;
    logic            keep;
    logic            push;
    logic            pop;
    logic            q_empty;
    fetch_entry_t    rsp_entry;
    fetch_entry_t    head;

    assign redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
    assign q_empty  = (q_count == '0);

    // Slots already promised: queued entries plus responses that will be kept.
    assign committed = {1'b0, q_count} + {1'b0, inflight} - {1'b0, drop};

    assign imem_req_valid = reset && !redirect_valid &&
                            (inflight < FULL) && (committed < {1'b0, FULL});
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign keep = imem_rsp_valid && (drop == '0) && !redirect_valid;

    assign rsp_entry.pc    = XLEN_DEFAULT'(rsp_pc);
    assign rsp_entry.instr = imem_rsp_data;

`ifdef IF_PREFETCH_BYPASS_EN
    logic bypass;
    assign bypass    = q_empty && keep;
    assign dec_valid = (!q_empty || keep) && !redirect_valid;
    assign dec_instr = bypass ? imem_rsp_data : head.instr;
    assign dec_pc    = bypass ? rsp_pc : XLEN'(head.pc);
    assign push      = keep && !(bypass && dec_ready);
`else
    assign dec_valid = !q_empty && !redirect_valid;
    assign dec_instr = head.instr;
    assign dec_pc    = XLEN'(head.pc);
    assign push      = keep;
`endif

    assign pop = dec_valid && dec_ready && !q_empty;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (rsp_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (q_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + CW'(accept) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= redir_pc;
                rsp_pc   <= redir_pc;
                drop     <= inflight - CW'(imem_rsp_valid);
            end else begin
                if (accept) fetch_pc <= fetch_pc + XLEN'(4);
                if (keep) rsp_pc <= rsp_pc + XLEN'(4);
                if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
            end
        end
    end

endmodule
